// File: rtl/alu_pkg.sv
// Shared constants and the decoded-op record for the ALU selector interface.
// Selector codes, RV32I opcode/funct7 constants used by the decoder and issue stage.
package alu_pkg;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SLL  = 4'b0001;
  localparam logic [3:0] SEL_SLT  = 4'b0010;
  localparam logic [3:0] SEL_SLTU = 4'b0011;
  localparam logic [3:0] SEL_XOR  = 4'b0100;
  localparam logic [3:0] SEL_SRL  = 4'b0101;
  localparam logic [3:0] SEL_OR   = 4'b0110;
  localparam logic [3:0] SEL_AND  = 4'b0111;
  localparam logic [3:0] SEL_SUB  = 4'b1000;
  localparam logic [3:0] SEL_SRA  = 4'b1001;
  localparam logic [3:0] SEL_BEQ  = 4'b1010;
  localparam logic [3:0] SEL_BNE  = 4'b1011;
  localparam logic [3:0] SEL_BLT  = 4'b1100;
  localparam logic [3:0] SEL_BGE  = 4'b1101;
  localparam logic [3:0] SEL_BLTU = 4'b1110;
  localparam logic [3:0] SEL_BGEU = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0] sel;
    logic       use_imm;
    logic       is_branch;
    logic       illegal;
  } alu_op_t;

  localparam alu_op_t ALU_OP_RESET = '{sel: SEL_ADD, use_imm: 1'b0, is_branch: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational RV32I -> ALU selector decode.
// Illegal encodings collapse to a plain ADD with only the illegal flag set.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     op
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [3:0] sel;
  logic       use_imm;
  logic       is_branch;
  logic       illegal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    sel       = SEL_ADD;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_ZERO)                     sel = {1'b0, f3};
        else if (f7 == F7_ALT && f3 == 3'b000) sel = SEL_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) sel = SEL_SRA;
        else                                   illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (f3)
          3'b001: begin
            if (f7 == F7_ZERO) sel = SEL_SLL;
            else               illegal = 1'b1;
          end
          3'b101: begin
            if (f7 == F7_ZERO)     sel = SEL_SRL;
            else if (f7 == F7_ALT) sel = SEL_SRA;
            else                   illegal = 1'b1;
          end
          default: sel = {1'b0, f3};
        endcase
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (f3)
          3'b000:  sel = SEL_BEQ;
          3'b001:  sel = SEL_BNE;
          3'b100:  sel = SEL_BLT;
          3'b101:  sel = SEL_BGE;
          3'b110:  sel = SEL_BLTU;
          3'b111:  sel = SEL_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC, OPC_LUI, OPC_JAL: begin
        use_imm = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // An illegal op must not leak partial flags from its opcode group.
    if (illegal) begin
      sel       = SEL_ADD;
      use_imm   = 1'b0;
      is_branch = 1'b0;
    end
  end

  assign op = '{sel: sel, use_imm: use_imm, is_branch: is_branch, illegal: illegal};

endmodule

// File: rtl/alu_op_issue.sv
// Decodes incoming instructions and issues them through a two-entry skid buffer
// (main reg M drives outputs, skid reg S catches one op during a stall), with saturating op counters.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sel,
  output logic             out_use_imm,
  output logic             out_is_branch,
  output logic             out_illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Handshake: a transfer happens on a side exactly when valid && ready are both high at the
  // rising edge; valid never waits for ready, and out_* stay stable while out_valid && !out_ready.

  alu_op_t in_op;
  alu_op_t m_op;
  alu_op_t s_op;
  logic    m_valid;
  logic    s_valid;
  logic    accept;
  logic    drain;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  alu_op_decode u_decode (
    .instr (in_instr),
    .op    (in_op)
  );

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_op    <= ALU_OP_RESET;
      s_op    <= ALU_OP_RESET;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || drain) begin
      // M is free this cycle: the skid entry is older than anything on the input.
      if (s_valid) begin
        m_op    <= s_op;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_op    <= in_op;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_op    <= in_op;
      s_valid <= 1'b1;
    end
  end

  assign out_valid     = m_valid;
  assign out_sel       = m_op.sel;
  assign out_use_imm   = m_op.use_imm;
  assign out_is_branch = m_op.is_branch;
  assign out_illegal   = m_op.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (drain) begin
      if (issued_cnt != CNT_MAX) issued_cnt <= issued_cnt + 1'b1;
      if (m_op.illegal && illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized and directed bench for alu_op_issue against a queue-based reference model.
module tb_alu_op_issue;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_sel;
  logic             out_use_imm;
  logic             out_is_branch;
  logic             out_illegal;
  logic             cnt_clr;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected queue of decoded ops {illegal,is_branch,use_imm,sel} in issue order; capacity two.
  logic [6:0]       exp_q[$];
  logic [CNT_W-1:0] exp_issued;
  logic [CNT_W-1:0] exp_illegal;

  alu_op_issue #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sel       (out_sel),
    .out_use_imm   (out_use_imm),
    .out_is_branch (out_is_branch),
    .out_illegal   (out_illegal),
    .cnt_clr       (cnt_clr),
    .issued_cnt    (issued_cnt),
    .illegal_cnt   (illegal_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Reference decode from the instruction-set tables.
  function automatic logic [6:0] ref_decode(input logic [31:0] ins);
    int   opc, fn3, fn7, sel;
    bit   imm, br, bad;
    int   b_tab[8];
    b_tab = '{10, 11, -1, -1, 12, 13, 14, 15};
    opc = int'(ins[6:0]); fn3 = int'(ins[14:12]); fn7 = int'(ins[31:25]);
    sel = 0; imm = 0; br = 0; bad = 0;
    if (opc == 'h33) begin
      if (fn7 == 0) sel = fn3;
      else if (fn7 == 'h20 && fn3 == 0) sel = 8;
      else if (fn7 == 'h20 && fn3 == 5) sel = 9;
      else bad = 1;
    end else if (opc == 'h13) begin
      imm = 1;
      if (fn3 == 1) begin
        if (fn7 == 0) sel = 1; else bad = 1;
      end else if (fn3 == 5) begin
        if (fn7 == 0) sel = 5; else if (fn7 == 'h20) sel = 9; else bad = 1;
      end else sel = fn3;
    end else if (opc == 'h63) begin
      br = 1;
      if (b_tab[fn3] < 0) bad = 1; else sel = b_tab[fn3];
    end else if (opc inside {'h03, 'h23, 'h67, 'h17, 'h37, 'h6F}) begin
      imm = 1;
    end else begin
      bad = 1;
    end
    if (bad) begin sel = 0; imm = 0; br = 0; end
    return {bad, br, imm, 4'(sel)};
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0)
      check("out_op", 32'({out_illegal, out_is_branch, out_use_imm, out_sel}), 32'(exp_q[0]));
    check("issued_cnt", 32'(issued_cnt), 32'(exp_issued));
    check("illegal_cnt", 32'(illegal_cnt), 32'(exp_illegal));
  endtask

  // Driver: called at a falling edge; checks current outputs, drives one cycle, advances the model.
  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic clr);
    bit         hs, acc;
    logic [6:0] head;
    check_outputs();
    in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl; cnt_clr = clr;
    hs  = (exp_q.size() > 0) && ordy;
    acc = iv && (exp_q.size() < 2);
    head = (exp_q.size() > 0) ? exp_q[0] : 7'd0;
    if (clr) begin
      exp_issued = '0; exp_illegal = '0;
    end else if (hs) begin
      if (exp_issued != '1) exp_issued++;
      if (head[6] && exp_illegal != '1) exp_illegal++;
    end
    if (fl) exp_q.delete();
    else begin
      if (hs) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_decode(ins));
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs[10];
    opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h67, 7'h17, 7'h37, 7'h6F, 7'h33};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  task automatic do_reset_check(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_op"}, 32'({out_illegal, out_is_branch, out_use_imm, out_sel}), 32'd0);
    check({tag, "_cnt"}, 32'({issued_cnt, illegal_cnt}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    exp_issued = '0; exp_illegal = '0;
    repeat (3) @(negedge clk);
    do_reset_check("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // add then sub, back to back
    step(1, 32'h00B50533, 1, 0, 0);
    check("add_sel", 32'(out_sel), 32'h0);
    step(1, 32'h40B50533, 1, 0, 0);
    check("sub_sel", 32'(out_sel), 32'h8);
    check("sub_back_to_back", 32'(out_valid), 32'd1);
    step(0, 0, 1, 0, 0);
    check("issued_two", 32'(issued_cnt), 32'd2);

    // shifts and illegal shift funct7
    step(1, 32'h4025D593, 1, 0, 0);
    check("srai", 32'({out_use_imm, out_sel}), 32'h19);
    step(1, 32'h0025D593, 1, 0, 0);
    check("srli", 32'({out_use_imm, out_sel}), 32'h15);
    step(1, 32'h4225D593, 1, 0, 0);
    check("bad_shift", 32'({out_illegal, out_sel}), 32'h10);
    step(0, 0, 1, 0, 1);

    // branches
    step(1, 32'h00B50463, 1, 0, 0);
    check("beq", 32'({out_is_branch, out_sel}), 32'h1A);
    step(1, 32'h00B52463, 1, 0, 0);
    check("bad_branch", 32'({out_illegal, out_is_branch, out_sel}), 32'h20);
    step(0, 0, 1, 0, 0);
    check("illegal_cnt_one", 32'(illegal_cnt), 32'd1);

    // stall with three ops offered: only two accepted, order preserved on release
    step(1, 32'h00B50533, 0, 0, 0);
    step(1, 32'h40B50533, 0, 0, 0);
    check("stall_ready_low", 32'(in_ready), 32'd0);
    step(1, 32'h00B54533, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("release_first", 32'(out_sel), 32'h8);
    step(0, 0, 1, 0, 0);
    check("release_empty", 32'(out_valid), 32'd0);

    // flush with M and S full and input offered
    step(1, 32'h00B57533, 0, 0, 0);
    step(1, 32'h00B56533, 0, 0, 0);
    step(1, 32'h00B51533, 0, 1, 0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    step(0, 0, 1, 0, 0);

    // saturation: 16 issued ops hold at 0xF, then clear with a same-cycle handshake
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 32'h00B50533, 1, 0, 0);
    check("sat_hold", 32'(issued_cnt), 32'hF);
    step(1, 32'h00B50533, 1, 0, 1);
    check("clr_wins", 32'(issued_cnt), 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 30) == 0);
    end

    // asynchronous reset mid-stream
    step(1, 32'h00B50533, 0, 0, 0);
    step(1, 32'h40B50533, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    do_reset_check("midreset");
    exp_q.delete(); exp_issued = '0; exp_illegal = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(0, 0, 1, 0, 0);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
